// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef struct packed {
        logic       extended;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

endpackage

// File: rtl/ps2_input_filter.sv
// Two-flop synchroniser plus run-length debounce for one PS/2 pin.
// Emits a one-cycle strobe when the filtered level goes from 1 to 0.
module ps2_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The run counter only advances while the synchronised sample disagrees
    // with the filtered level; any agreeing sample restarts the run.
    always_comb begin
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_d = sync2_q;
                fall_d  = level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin;
            sync2_q <= sync1_q;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, folds E0/F0 prefixes into
// make/break/extended events and queues them in a show-ahead FIFO.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic       valid,
    output logic [7:0] code,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_err,
    output logic       overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic clk_level_unused, clk_fall;
    logic data_lvl, data_fall_unused;

    ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk  (clk),
        .reset(reset),
        .pin  (ps2_clk),
        .level(clk_level_unused),
        .fall (clk_fall)
    );

    ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk  (clk),
        .reset(reset),
        .pin  (ps2_data),
        .level(data_lvl),
        .fall (data_fall_unused)
    );

    ps2_state_e    state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] tmo_q;
    logic          brk_pend_q, ext_pend_q;
    logic          frame_err_q;
    logic          wr_req_q;
    ps2_event_t    wr_evt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            brk_pend_q  <= 1'b0;
            ext_pend_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_req_q    <= 1'b0;
            wr_evt_q    <= '0;
        end else begin
            frame_err_q <= 1'b0;
            wr_req_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    tmo_q <= '0;
                    if (clk_fall && !data_lvl) begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                    end
                end
                default: begin
                    if (clk_fall) begin
                        tmo_q <= '0;
                        case (state_q)
                            DATA: begin
                                shift_q   <= {data_lvl, shift_q[7:1]};
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                if (bit_cnt_q == 3'd7)
                                    state_q <= PARITY;
                            end
                            PARITY: begin
                                parity_q <= data_lvl;
                                state_q  <= STOP;
                            end
                            STOP: begin
                                state_q <= IDLE;
                                // Odd parity: data plus parity must hold an odd count of ones.
                                if (data_lvl && (^{shift_q, parity_q})) begin
                                    if (shift_q == PS2_BREAK) begin
                                        brk_pend_q <= 1'b1;
                                    end else if (shift_q == PS2_EXT) begin
                                        ext_pend_q <= 1'b1;
                                    end else begin
                                        wr_req_q          <= 1'b1;
                                        wr_evt_q.extended <= ext_pend_q;
                                        wr_evt_q.brk      <= brk_pend_q;
                                        wr_evt_q.code     <= shift_q;
                                        brk_pend_q        <= 1'b0;
                                        ext_pend_q        <= 1'b0;
                                    end
                                end else begin
                                    frame_err_q <= 1'b1;
                                    brk_pend_q  <= 1'b0;
                                    ext_pend_q  <= 1'b0;
                                end
                            end
                            default: state_q <= IDLE;
                        endcase
                    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_q     <= IDLE;
                        tmo_q       <= '0;
                        frame_err_q <= 1'b1;
                        brk_pend_q  <= 1'b0;
                        ext_pend_q  <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
            endcase
        end
    end

    ps2_event_t    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          full, empty, push, pop;
    ps2_event_t    head;

    // A pop in the same cycle frees a slot, so a write while full still lands.
    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = rd_en && !empty;
        push       = wr_req_q && (!full || pop);
        overflow_d = wr_req_q && full && !pop;
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q[AW-1:0]] <= wr_evt_q;
    end

    assign head        = mem[rd_ptr_q[AW-1:0]];
    assign valid       = !empty;
    assign code        = empty ? 8'h00 : head.code;
    assign is_break    = !empty && head.brk;
    assign is_extended = !empty && head.extended;
    assign frame_err   = frame_err_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed and randomized frames driven onto the PS/2 pins; decoded events,
// error pulses and overflow pulses are compared against an event-level model.
module tb_ps2_keyboard_rx;

    localparam int HALF    = 20;
    localparam int TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic       valid;
    logic [7:0] code;
    logic       is_break, is_extended, frame_err, overflow;

    ps2_keyboard_rx #(
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(TIMEOUT),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_en      (rd_en),
        .valid      (valid),
        .code       (code),
        .is_break   (is_break),
        .is_extended(is_extended),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int ovf_seen = 0;
    int err_exp  = 0;
    int ovf_exp  = 0;
    bit m_brk = 0, m_ext = 0;
    logic [9:0] exp_q[$];

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_seen++;
        if (overflow === 1'b1) ovf_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Event-level reference: one call per complete frame seen by the receiver.
    function automatic void model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            err_exp++;
            m_brk = 0;
            m_ext = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else begin
            if (exp_q.size() == 4) ovf_exp++;
            else exp_q.push_back({m_ext, m_brk, b});
            m_brk = 0;
            m_ext = 0;
        end
    endfunction

    // Drives the first nbits of a frame; glitch adds a short low spike on ps2_clk.
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            if (glitch) begin
                repeat (5) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (2) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (HALF - 7) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
        send_bits(b, bad_par, 11, glitch);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (30) @(negedge clk);
        model_frame(b, !bad_par);
    endtask

    task automatic pop_check(input string tag);
        logic [9:0] ev;
        ev = exp_q.pop_front();
        @(negedge clk);
        check({tag, ".valid"}, valid, 1'b1);
        check({tag, ".code"}, code, ev[7:0]);
        check({tag, ".brk"}, is_break, ev[8]);
        check({tag, ".ext"}, is_extended, ev[9]);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) pop_check(tag);
        @(negedge clk);
        check({tag, ".empty"}, valid, 1'b0);
        check({tag, ".code0"}, code, 8'h00);
        check({tag, ".errs"}, err_seen, err_exp);
        check({tag, ".ovfs"}, ovf_seen, ovf_exp);
    endtask

    initial begin
        logic [7:0] c;
        bit e, k, bad;

        repeat (3) @(negedge clk);
        check("rst.valid", valid, 1'b0);
        check("rst.code", code, 8'h00);
        check("rst.err", frame_err, 1'b0);
        check("rst.ovf", overflow, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // make / break of 0x75
        send_frame(8'h75, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 1);
        drain("mk_brk");

        // extended break
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h6B, 0, 0);
        drain("ext_brk");

        // parity error then recovery
        send_frame(8'h1C, 1, 0);
        check("par.novalid", valid, 1'b0);
        send_frame(8'h1C, 0, 0);
        drain("par");

        // timeout after E0 and four data bits
        send_frame(8'hE0, 0, 0);
        send_bits(8'h1C, 0, 5, 0);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (TIMEOUT + 60) @(negedge clk);
        err_exp++;
        m_brk = 0;
        m_ext = 0;
        check("tmo.err", err_seen, err_exp);
        send_frame(8'h1C, 0, 0);
        drain("tmo");

        // five makes with no reads: fifth dropped
        for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 0, 0);
        check("ovf.valid", valid, 1'b1);
        check("ovf.count", ovf_seen, 1);
        drain("ovf");

        // reset mid-frame with a queued event and a pending break
        send_frame(8'h16, 0, 0);
        send_frame(8'hF0, 0, 0);
        check("mid.valid", valid, 1'b1);
        send_bits(8'h29, 0, 6, 0);
        reset = 1'b1;
        #1;
        check("mid.rst.valid", valid, 1'b0);
        check("mid.rst.code", code, 8'h00);
        check("mid.rst.brk", is_break, 1'b0);
        check("mid.rst.ext", is_extended, 1'b0);
        check("mid.rst.err", frame_err, 1'b0);
        check("mid.rst.ovf", overflow, 1'b0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        exp_q.delete();
        m_brk = 0;
        m_ext = 0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        send_frame(8'h29, 0, 0);
        drain("mid");

        // randomized sequences
        for (int i = 0; i < 12; i++) begin
            e   = ($urandom_range(0, 3) == 0);
            k   = ($urandom_range(0, 2) == 0);
            bad = ($urandom_range(0, 7) == 0);
            do c = 8'($urandom); while (c == 8'hF0 || c == 8'hE0);
            if (e) send_frame(8'hE0, 0, 0);
            if (k) send_frame(8'hF0, 0, ($urandom_range(0, 1) == 1));
            send_frame(c, bad, ($urandom_range(0, 1) == 1));
            if (i % 4 == 3) drain("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
